lshift_seq: RTL and testbench
=============================

// Module: lshift_seq
//
// PURPOSE
//   Multi-cycle logical left shifter; the other-direction companion of the
//   combinational arithmetic right shifter in the ALU.
//   - Shifts one bit position per clock under a start/busy/done handshake.
//   - Reports the last bit shifted out on carry_out.
//   - Serves ALU SLL ops where area matters more than latency.
//
// PARAMETERS
//   WIDTH    32  data path width in bits (>= 2)
//   SHAMT_W  6   shift_amount width; the full range 0..2^SHAMT_W-1 is accepted
//
// PORTS
//   clk           input   1        rising-edge clock; the only clock
//   rst_n         input   1        reset, asynchronous, active-low
//   start         input   1        request; sampled only in IDLE
//   data_in       input   WIDTH    operand, captured on the accepted start
//   shift_amount  input   SHAMT_W  shift count, captured on the accepted start
//   busy          output  1        1 while state != IDLE
//   done          output  1        one-cycle pulse: result valid on data_out
//   data_out      output  WIDTH    working/result register
//   carry_out     output  1        last bit shifted out of bit WIDTH-1
//
// BEHAVIOUR
//   - Reset (rst_n=0, any time, asynchronous):
//       state=IDLE; count=0; busy=0; done=0; data_out=0; carry_out=0.
//   - Reset mid-operation aborts the operation; no done pulse follows.
//   - States:
//       IDLE
//         Accepted start at edge k: data_out<=data_in, carry_out<=0.
//         Latch N = min(shift_amount, WIDTH) into count.
//         Next state is SHIFT if N>0, otherwise DONE.
//       SHIFT
//         Each edge: data_out<={data_out[WIDTH-2:0],1'b0},
//         carry_out<=data_out[WIDTH-1], count<=count-1.
//         The edge at which count==1 performs the final shift -> DONE.
//       DONE
//         done=1 and busy=1 for exactly one cycle; next edge -> IDLE.
//   - Latency: done is high in the cycle after edge k+N.
//       N=0 -> done in the cycle after edge k (result = data_in, carry=0).
//   - Amounts >= WIDTH clamp to WIDTH:
//       data_out=0; carry_out=data_in[0].
//       Worst case is WIDTH+1 cycles, start edge to IDLE.
//   - start while busy (SHIFT or DONE) is ignored, not queued.
//     data_in and shift_amount are don't-care outside the accepted start.
//   - data_out/carry_out: intermediate values during SHIFT; from DONE onward
//     they hold the result until the next accepted start.
//   - Back-to-back ops: the earliest new start is accepted in the IDLE cycle
//     after DONE.
//   - done and busy are registered state decodes; no combinational path
//     from inputs to outputs.
//
// TESTING
//   1. data_in=32'h0000_0001, amt=4, start 1 cycle
//        -> busy 1 for 5 cycles; done after 4th shift edge;
//           data_out=32'h0000_0010, carry_out=0.
//   2. data_in=32'h8000_0003, amt=1
//        -> done 1 cycle after start edge; data_out=32'h0000_0006,
//           carry_out=1.
//   3. amt=0, data_in=32'hDEAD_BEEF
//        -> done in cycle after start edge; data_out=32'hDEAD_BEEF,
//           carry_out=0, no SHIFT cycles.
//   4. amt=63 and amt=32, data_in=32'hFFFF_FFFF
//        -> both take 32 shifts; data_out=0, carry_out=1.
//   5. Start pulsed again during SHIFT and during DONE
//        -> ignored; first result intact.
//      New start in the following IDLE cycle -> accepted.
//   6. rst_n low mid-SHIFT (amt=20, after 5 shifts)
//        -> outputs 0 immediately, no done pulse.
//      Operation after release behaves as test 1.

Source files
------------

// File: rtl/lshift_seq_if.sv
// Handshake and data bundle for the multi-cycle logical left shifter.
//   master : requester side, drives start/data_in/shift_amount
//   slave  : shifter side, drives busy/done/data_out/carry_out
interface lshift_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
);
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;
  logic               carry_out;

  modport master (
    output start, data_in, shift_amount,
    input  busy, done, data_out, carry_out
  );

  modport slave (
    input  start, data_in, shift_amount,
    output busy, done, data_out, carry_out
  );
endinterface

// File: rtl/lshift_seq.sv
// Multi-cycle logical left shifter: one bit position per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    lshift_seq_if.slave
//            start         request, sampled only in IDLE
//            data_in       operand, captured on the accepted start
//            shift_amount  shift count, clamped to WIDTH
//            busy          high while not IDLE
//            done          one-cycle result-valid pulse
//            data_out      working/result register
//            carry_out     last bit shifted out of bit WIDTH-1
module lshift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  lshift_seq_if.slave  bus
);

  // count must be able to hold WIDTH itself (the clamped maximum)
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   data_q;
  logic               carry_q;
  logic [CNT_W-1:0]   n_clamp;
  logic               accept;

  // Amounts of WIDTH or more all produce the same result as exactly WIDTH
  // shifts, so clamp here and keep the counter narrow.
  always_comb begin
    n_clamp = CNT_W'(WIDTH);
    if (32'(bus.shift_amount) < 32'(WIDTH))
      n_clamp = CNT_W'(bus.shift_amount);
  end

  assign accept = (state_q == IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept)
          state_d = (n_clamp != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        // the edge seen with count==1 performs the final shift
        if (count_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, shifting, countdown. Outside SHIFT and the
  // accepting IDLE edge everything holds, so the result stays visible
  // from DONE until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.data_in;
            carry_q <= 1'b0;
            count_q <= n_clamp;
          end
        end
        SHIFT: begin
          data_q  <= {data_q[WIDTH-2:0], 1'b0};
          carry_q <= data_q[WIDTH-1];
          count_q <= count_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the state register only; no input reaches them
  // combinationally.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.data_out  = data_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_lshift_seq.sv
// Directed bench for lshift_seq with hand-computed expectations.
module tb_lshift_seq;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 6;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  lshift_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  lshift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one start, follow it to the done pulse and check result,
  // latency (edges after start edge), busy duration and single-cycle done.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [5:0] amt,
                        input logic [31:0] exp_d, input logic exp_c, input int exp_lat);
    int lat;
    int busy_cnt;
    bus.start        = 1'b1;
    bus.data_in      = din;
    bus.shift_amount = amt;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.data_in      = 32'h5A5A_A5A5;
    bus.shift_amount = 6'd7;
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat + 1));
    chk({tag, " data_out"}, 64'(bus.data_out), 64'(exp_d));
    chk({tag, " carry_out"}, 64'(bus.carry_out), 64'(exp_c));
    @(posedge clk); #1;
    chk({tag, " done_drop"}, 64'(bus.done), 64'd0);
    chk({tag, " idle"}, 64'(bus.busy), 64'd0);
    chk({tag, " hold_data"}, 64'(bus.data_out), 64'(exp_d));
  endtask

  initial begin
    int dcnt;
    bus.start        = 1'b0;
    bus.data_in      = '0;
    bus.shift_amount = '0;
    rst_n = 1'b0;
    #1;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst data", 64'(bus.data_out), 64'd0);
    chk("rst carry", 64'(bus.carry_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    run_op("t1",  32'h0000_0001, 6'd4,  32'h0000_0010, 1'b0, 4);
    run_op("t2",  32'h8000_0003, 6'd1,  32'h0000_0006, 1'b1, 1);
    run_op("t3",  32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1'b0, 0);
    run_op("t4a", 32'hFFFF_FFFF, 6'd63, 32'h0000_0000, 1'b1, 32);
    run_op("t4b", 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b1, 32);
    run_op("t4c", 32'hFFFF_FFFE, 6'd40, 32'h0000_0000, 1'b0, 32);
    run_op("t31", 32'h0000_0003, 6'd31, 32'h8000_0000, 1'b1, 31);
    run_op("t8",  32'h1234_5678, 6'd8,  32'h3456_7800, 1'b0, 8);

    // start held high through SHIFT and DONE must be ignored
    bus.start = 1'b1; bus.data_in = 32'h0000_0001; bus.shift_amount = 6'd3;
    @(posedge clk); #1;
    bus.data_in = 32'hFFFF_FFFF; bus.shift_amount = 6'd1;
    dcnt = 0;
    while (!bus.done && dcnt < 100) begin
      @(posedge clk); #1;
      dcnt++;
    end
    chk("t5 latency", 64'(dcnt), 64'd3);
    chk("t5 data", 64'(bus.data_out), 64'h0000_0008);
    chk("t5 carry", 64'(bus.carry_out), 64'd0);
    @(posedge clk); #1;   // DONE -> IDLE, start seen in DONE ignored
    chk("t5 idle", 64'(bus.busy), 64'd0);
    chk("t5 hold", 64'(bus.data_out), 64'h0000_0008);
    @(posedge clk); #1;   // accepted in IDLE: 0xFFFFFFFF << 1
    bus.start = 1'b0;
    chk("t5 accept", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    chk("t5b done", 64'(bus.done), 64'd1);
    chk("t5b data", 64'(bus.data_out), 64'hFFFF_FFFE);
    chk("t5b carry", 64'(bus.carry_out), 64'd1);
    @(posedge clk); #1;

    // asynchronous reset mid-SHIFT
    bus.start = 1'b1; bus.data_in = 32'h0000_0001; bus.shift_amount = 6'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("t6 mid data", 64'(bus.data_out), 64'h0000_0020);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst busy", 64'(bus.busy), 64'd0);
    chk("t6 rst data", 64'(bus.data_out), 64'd0);
    chk("t6 rst carry", 64'(bus.carry_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    dcnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    chk("t6 no done", 64'(dcnt), 64'd0);
    run_op("t6 after", 32'h0000_0001, 6'd4, 32'h0000_0010, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
